// File: rtl/present_ti_unmask_check_pkg.sv
// Shared share-packing constants and the recombine helper for the TI unmask checker.
// A nibble is carried as NSHARES Boolean shares; share i sits in bits [i*NIBBLE +: NIBBLE].
package present_ti_unmask_check_pkg;

  localparam int NSHARES = 3;
  localparam int NIBBLE  = 4;
  localparam int SHARE_W = NSHARES * NIBBLE;

  typedef logic [NIBBLE-1:0]  nibble_t;
  typedef logic [SHARE_W-1:0] shares_t;

  // XOR of all shares of one nibble; only ever used directly in front of a register.
  function automatic nibble_t recombine(input shares_t s);
    nibble_t acc;
    acc = '0;
    for (int i = 0; i < NSHARES; i++) begin
      acc = acc ^ s[i*NIBBLE +: NIBBLE];
    end
    return acc;
  endfunction

endpackage

// File: rtl/present_ti_unmask_check_ti_recombine.sv
// Recombines the shares of one nibble straight into a register, so the unmasked
// value only ever exists as a flop output.
module ti_recombine
  import present_ti_unmask_check_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    load,
  input  shares_t shares,
  output nibble_t unmasked
);

  nibble_t unmasked_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      unmasked_reg <= '0;
    end else if (load) begin
      unmasked_reg <= recombine(shares);
    end
  end

  assign unmasked = unmasked_reg;

endmodule

// File: rtl/present_ti_unmask_check.sv
// Two-stage unmask-and-compare pipeline for a duplicated 3-share PRESENT datapath,
// with valid/ready flow control, optional output suppression and fault accounting.
module present_ti_unmask_check
  import present_ti_unmask_check_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter bit SUPPRESS = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SHARE_W-1:0] share_p,
  input  logic [SHARE_W-1:0] share_r,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NIBBLE-1:0]  data_out,
  output logic               fault_flag,
  output logic               alarm,
  output logic [CNT_W-1:0]   fault_cnt,
  input  logic               clr_alarm
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             s1_valid_reg;
  logic             out_valid_reg;
  logic             fault_reg;
  nibble_t          data_reg;
  logic             alarm_reg;
  logic [CNT_W-1:0] fault_cnt_reg;

  nibble_t u_p;
  nibble_t u_r;
  logic    s2_open;
  logic    s1_move;
  logic    accept;
  logic    mismatch;
  logic    new_fault;

  // Stage 2 can take a new entry when empty or being drained this cycle.
  assign s2_open   = !out_valid_reg || out_ready;
  assign s1_move   = s1_valid_reg && s2_open;
  assign in_ready  = !s1_valid_reg || s2_open;
  assign accept    = in_valid && in_ready;
  assign mismatch  = (u_p != u_r);
  assign new_fault = s1_move && mismatch;

  ti_recombine u_rec_p (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .shares   (share_p),
    .unmasked (u_p)
  );

  ti_recombine u_rec_r (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .shares   (share_r),
    .unmasked (u_r)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
    end else if (accept) begin
      s1_valid_reg <= 1'b1;
    end else if (s1_move) begin
      s1_valid_reg <= 1'b0;
    end
  end

  // Stage 2 holds while stalled, so a held fault is seen by the counters only once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      fault_reg     <= 1'b0;
      data_reg      <= '0;
    end else if (s2_open) begin
      out_valid_reg <= s1_valid_reg;
      fault_reg     <= s1_valid_reg && mismatch;
      if (s1_valid_reg) begin
        data_reg <= (SUPPRESS && mismatch) ? nibble_t'(0) : u_p;
      end
    end
  end

  // A fault arriving on the same edge as a clear wins: the count restarts at one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm_reg     <= 1'b0;
      fault_cnt_reg <= '0;
    end else if (new_fault) begin
      alarm_reg <= 1'b1;
      if (clr_alarm) begin
        fault_cnt_reg <= CNT_W'(1);
      end else if (fault_cnt_reg != CNT_MAX) begin
        fault_cnt_reg <= fault_cnt_reg + CNT_W'(1);
      end
    end else if (clr_alarm) begin
      alarm_reg     <= 1'b0;
      fault_cnt_reg <= '0;
    end
  end

  assign out_valid  = out_valid_reg;
  assign fault_flag = fault_reg;
  assign data_out   = data_reg;
  assign alarm      = alarm_reg;
  assign fault_cnt  = fault_cnt_reg;

endmodule

// File: tb/tb_present_ti_unmask_check.sv
// Self-checking bench for present_ti_unmask_check: directed table, scripted corner
// sequences, and randomized traffic against a queue-based transaction model.
module tb_present_ti_unmask_check;

  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic             clr_alarm = 1'b0;
  logic [11:0]      share_p = '0;
  logic [11:0]      share_r = '0;
  logic             in_ready;
  logic             out_valid;
  logic [3:0]       data_out;
  logic             fault_flag;
  logic             alarm;
  logic [CNT_W-1:0] fault_cnt;

  present_ti_unmask_check #(.CNT_W(CNT_W), .SUPPRESS(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .share_p    (share_p),
    .share_r    (share_r),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .data_out   (data_out),
    .fault_flag (fault_flag),
    .alarm      (alarm),
    .fault_cnt  (fault_cnt),
    .clr_alarm  (clr_alarm)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: queue of accepted pairs, each tagged with its accept edge.
  typedef struct {
    logic [3:0] up;
    logic [3:0] ur;
    int         a;
    bit         seen;
  } item_t;

  item_t q[$];
  int    edge_cnt = 0;
  int    m_cnt = 0;
  bit    m_alarm = 1'b0;
  bit    clr_prev = 1'b0;
  int    popped = 0;
  logic  last_in_ready;

  always @(posedge clk) edge_cnt++;

  function automatic logic [3:0] unmask(input logic [11:0] s);
    return s[3:0] ^ s[7:4] ^ s[11:8];
  endfunction

  // One clock cycle: drive, check against the model, advance the model, wait for the edge.
  task automatic cycle(input bit iv, input logic [11:0] sp, input logic [11:0] sr,
                       input bit ordy, input bit clr, output bit acc);
    bit         vis;
    bit         exp_ir;
    logic [3:0] exp_d;
    in_valid = iv; share_p = sp; share_r = sr; out_ready = ordy; clr_alarm = clr;
    #1;
    if (clr_prev) begin m_cnt = 0; m_alarm = 1'b0; end
    vis = (q.size() > 0) && (q[0].a < edge_cnt);
    if (vis && !q[0].seen) begin
      q[0].seen = 1'b1;
      if (q[0].up != q[0].ur) begin
        m_alarm = 1'b1;
        if (m_cnt < CNT_MAX) m_cnt++;
      end
    end
    chk("out_valid", out_valid, vis);
    if (vis) begin
      exp_d = (q[0].up != q[0].ur) ? 4'h0 : q[0].up;
      chk("data_out", data_out, exp_d);
      chk("fault_flag", fault_flag, q[0].up != q[0].ur);
    end
    exp_ir = (q.size() < 2) || ordy;
    last_in_ready = in_ready;
    chk("in_ready", in_ready, exp_ir);
    chk("alarm", alarm, m_alarm);
    chk("fault_cnt", fault_cnt, m_cnt);
    acc = iv && exp_ir;
    if (vis && ordy) begin void'(q.pop_front()); popped++; end
    if (acc) q.push_back('{unmask(sp), unmask(sr), edge_cnt + 1, 1'b0});
    clr_prev = clr;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_alarm = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_data_out", data_out, 4'h0);
    chk("rst_fault_flag", fault_flag, 1'b0);
    chk("rst_alarm", alarm, 1'b0);
    chk("rst_fault_cnt", fault_cnt, 0);
    q.delete(); m_cnt = 0; m_alarm = 1'b0; clr_prev = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [11:0] sp;
    logic [11:0] sr;
    logic [3:0]  exp_data;
    bit          exp_fault;
    bit          exp_alarm;
    int          exp_cnt;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    bit          acc;
    bit          dropped;
    int          k;
    int          pop0;
    logic [11:0] sp;
    logic [11:0] sr;
    logic [3:0]  m;
    logic [11:0] ps[4];
    logic [11:0] pr[4];

    vecs[0] = '{12'hA53, 12'hA53, 4'hC, 1'b0, 1'b0, 0};
    vecs[1] = '{12'h000, 12'h000, 4'h0, 1'b0, 1'b0, 0};
    vecs[2] = '{12'hFFF, 12'hFFF, 4'hF, 1'b0, 1'b0, 0};
    vecs[3] = '{12'h456, 12'h456, 4'h7, 1'b0, 1'b0, 0};
    vecs[4] = '{12'hA53, 12'hA52, 4'h0, 1'b1, 1'b1, 1};
    vecs[5] = '{12'h7F1, 12'h7F0, 4'h0, 1'b1, 1'b1, 2};
    vecs[6] = '{12'h123, 12'h213, 4'h0, 1'b0, 1'b1, 2};

    #2;
    do_reset();
    #1;
    chk("post_rst_in_ready", in_ready, 1'b1);

    // Directed table: single pair, result exactly two edges later.
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; share_p = vecs[i].sp; share_r = vecs[i].sr; out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("vec_early_out_valid", out_valid, 1'b0);
      @(posedge clk); @(negedge clk);
      #1;
      chk("vec_out_valid", out_valid, 1'b1);
      chk("vec_data_out", data_out, vecs[i].exp_data);
      chk("vec_fault_flag", fault_flag, vecs[i].exp_fault);
      chk("vec_alarm", alarm, vecs[i].exp_alarm);
      chk("vec_fault_cnt", fault_cnt, vecs[i].exp_cnt);
    end

    do_reset();

    // Randomized traffic with stalls, mismatches, remasked-but-equal pairs and clears.
    for (int i = 0; i < 1500; i++) begin
      sp = 12'($urandom);
      case ($urandom_range(0, 7))
        0, 1: sr = sp ^ (12'(1) << $urandom_range(0, 11));
        2, 3: begin m = 4'($urandom); sr = sp ^ {4'h0, m, m}; end
        default: sr = sp;
      endcase
      cycle($urandom_range(0, 3) != 0, sp, sr, $urandom_range(0, 3) != 0,
            $urandom_range(0, 31) == 0, acc);
    end

    // Stream of 4 pairs, consumer stalls 3 cycles while a fault sits in stage 2.
    do_reset();
    ps = '{12'hA53, 12'h123, 12'h456, 12'hFFF};
    pr = '{12'hA52, 12'h123, 12'h456, 12'hFFF};
    dropped = 1'b0; k = 0; pop0 = popped;
    for (int c = 0; c < 30; c++) begin
      if (k == 4 && q.size() == 0) break;
      cycle(k < 4, ps[k < 4 ? k : 0], pr[k < 4 ? k : 0], !(c >= 1 && c <= 3), 1'b0, acc);
      if (last_in_ready === 1'b0) dropped = 1'b1;
      if (acc) k++;
    end
    chk("stall_in_ready_dropped", dropped, 1'b1);
    chk("stall_all_delivered", popped - pop0, 4);
    chk("stall_fault_counted_once", fault_cnt, 1);

    // Saturation, then a clear coincident with a fault entering stage 2.
    for (int i = 0; i < 300; i++) begin
      sp = 12'($urandom);
      cycle(1'b1, sp, sp ^ 12'h100, 1'b1, 1'b0, acc);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 12'h0, 12'h0, 1'b1, 1'b0, acc);
    chk("sat_fault_cnt", fault_cnt, 255);
    chk("sat_alarm", alarm, 1'b1);
    cycle(1'b1, 12'hA53, 12'hA52, 1'b1, 1'b0, acc);
    cycle(1'b0, 12'h0, 12'h0, 1'b1, 1'b1, acc);
    cycle(1'b0, 12'h0, 12'h0, 1'b1, 1'b0, acc);
    chk("clr_vs_fault_cnt", fault_cnt, 1);
    chk("clr_vs_fault_alarm", alarm, 1'b1);

    // Reset with both stages occupied: nothing stale may appear afterwards.
    cycle(1'b1, 12'h111, 12'h111, 1'b0, 1'b0, acc);
    cycle(1'b1, 12'h222, 12'h222, 1'b0, 1'b0, acc);
    #1;
    chk("full_before_rst_out_valid", out_valid, 1'b1);
    chk("full_before_rst_in_ready", in_ready, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst_async_out_valid", out_valid, 1'b0);
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b0, 12'h0, 12'h0, 1'b1, 1'b0, acc);
    cycle(1'b1, 12'h456, 12'h456, 1'b1, 1'b0, acc);
    for (int i = 0; i < 3; i++) cycle(1'b0, 12'h0, 12'h0, 1'b1, 1'b0, acc);
    chk("post_rst_delivered_fresh_only", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/present_ti_unmask_check.md
PRESENT_TI_UNMASK_CHECK -- requirements
Module: present_ti_unmask_check

Interface
REQ-001 SHALL have parameter CNT_W, default 8, meaning width of the saturating fault counter.
REQ-002 SHALL have parameter SUPPRESS, default 1, meaning that data_out is forced to 4'h0 on a detected fault (0 means the primary value passes through).
REQ-003 SHALL have port clk  input  1  the single clock; all flops are rising-edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  a share pair is presented.
REQ-006 SHALL have port in_ready  output  1  the block accepts the pair this cycle.
REQ-007 SHALL have port share_p  input  12  primary-path 3-share nibble: share0 [3:0], share1 [7:4], share2 [11:8].
REQ-008 SHALL have port share_r  input  12  redundant-path 3-share nibble, same packing.
REQ-009 SHALL have port out_valid  output  1  a result is presented.
REQ-010 SHALL have port out_ready  input  1  the consumer takes the result.
REQ-011 SHALL have port data_out  output  4  recombined (unmasked) nibble.
REQ-012 SHALL have port fault_flag  output  1  the current result mismatched; qualified by out_valid.
REQ-013 SHALL have port alarm  output  1  sticky fault indicator.
REQ-014 SHALL have port fault_cnt  output  CNT_W  saturating count of detected faults.
REQ-015 SHALL have port clr_alarm  input  1  synchronous clear of alarm and fault_cnt.

Function
REQ-016 SHALL accept a pair on the rising clk edge where in_valid && in_ready are both high.
REQ-017 Stage 1 SHALL register the primary unmasked value u_p = share0^share1^share2 and the redundant value u_r computed the same way, with a valid bit; shares SHALL never be combined before this register.
REQ-018 Stage 2 SHALL register data_out, fault_flag = (u_p != u_r) and out_valid; data_out SHALL be u_p, or 4'h0 when the pair mismatches and SUPPRESS=1.
REQ-019 Latency SHALL be exactly 2 cycles from acceptance to out_valid when out_ready is held high; throughput SHALL be 1 pair per cycle.
REQ-020 Stage 2 SHALL hold its contents while out_valid && !out_ready; stage 1 SHALL advance only when stage 2 is empty or being drained.
REQ-021 in_ready SHALL be high when stage 1 is empty, or when stage 1 can advance in the same cycle; it SHALL be combinational from out_ready and the stage valid bits only, with no path from in_valid.
REQ-022 alarm SHALL set on the edge where a mismatching result enters stage 2, and SHALL stay set until clr_alarm or rst.
REQ-023 fault_cnt SHALL increment by 1 at the same edge as REQ-022 and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-024 When clr_alarm and a new fault occur on the same edge, the fault SHALL win: alarm=1 and fault_cnt=1.
REQ-025 A stalled result SHALL be counted only once, regardless of how long it is held.
REQ-026 The outputs SHALL not depend on the share values beyond the recombined XOR; no share SHALL reach an output unmasked except through REQ-017/018.

Reset
REQ-027 Asserting rst SHALL immediately clear all valid bits, out_valid, fault_flag, alarm, fault_cnt and data_out (4'h0).
REQ-028 Data in flight at reset SHALL be discarded and never presented.
REQ-029 in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-030 A shared package SHALL hold the share-packing constants (NSHARES=3, NIBBLE=4) and a share-recombine function.
REQ-031 The block SHALL instantiate exactly one sub-module, ti_recombine, twice (primary and redundant paths); this sub-module XORs 3 shares of one nibble.
REQ-032 The block SHALL contain no latches, and every flop SHALL use the async active-high rst.

Verification
REQ-033 Bench SHALL cover: share_p=share_r=12'hA53 -> 2 cycles later data_out=4'hC, fault_flag=0, alarm=0.
REQ-034 Bench SHALL cover: share_p=12'hA53, share_r=12'hA52 -> data_out=4'h0, fault_flag=1, alarm=1, fault_cnt=1.
REQ-035 Bench SHALL cover: stream of 4 pairs with out_ready low for 3 cycles mid-stream -> in_ready drops once both stages are full; all 4 results arrive in order, none duplicated or lost; a stalled fault counts once.
REQ-036 Bench SHALL cover: 300 consecutive mismatches with CNT_W=8 -> fault_cnt=255; then clr_alarm coincident with a mismatch -> alarm=1, fault_cnt=1.
REQ-037 Bench SHALL cover: rst pulsed with both stages full -> out_valid=0 immediately, and no stale result after rst is released.
